// File: rtl/axi4lite_native_master.sv
// axi4lite_native_master
//   Bridges a PicoRV32-style native memory port onto an AXI4-Lite master,
//   one transaction at a time. Every AXI output comes straight from a flop.
//   A response-phase timeout completes the request with mem_error=1 and
//   leaves a stale flag so the late response is drained, not forwarded.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb   native request (wstrb==0 -> read)
//   mem_ready/mem_rdata/mem_error                       native completion pulse + data/status
//   mem_axi_aw*/w*/b*/ar*/r*                            AXI4-Lite master channels
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. A valid, once raised, stays up with stable payload until that
// edge; ready may be asserted independently of valid.
module axi4lite_native_master #(
    parameter bit TIMEOUT_EN     = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    input  logic [31:0] mem_axi_rdata,
    output logic        mem_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R_RESP, S_WR, S_B_RESP, S_DONE
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        stale_r_q, stale_r_d, stale_b_q, stale_b_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] rdata_d;
    logic        error_d, ready_d, capture;
    logic        arvalid_d, awvalid_d, wvalid_d, rready_d, bready_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        stale_r_d = stale_r_q;
        stale_b_d = stale_b_q;
        timer_d   = timer_q;
        rdata_d   = mem_rdata;
        error_d   = mem_error;
        ready_d   = 1'b0;
        capture   = 1'b0;

        // Orphaned responses after a timeout: swallow the first one.
        if (stale_r_q && mem_axi_rready && mem_axi_rvalid) stale_r_d = 1'b0;
        if (stale_b_q && mem_axi_bready && mem_axi_bvalid) stale_b_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_valid && !mem_ready) begin
                    if (mem_wstrb == 4'b0000) begin
                        if (!stale_r_q) begin
                            capture = 1'b1;
                            state_d = S_AR;
                        end
                    end else if (!stale_b_q) begin
                        capture   = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR;
                    end
                end
            end
            S_AR: begin
                if (mem_axi_arvalid && mem_axi_arready) begin
                    state_d = S_R_RESP;
                    timer_d = '0;
                end
            end
            S_R_RESP: begin
                // A response on the timeout cycle still wins.
                if (mem_axi_rvalid && mem_axi_rready) begin
                    rdata_d = mem_axi_rdata;
                    error_d = 1'b0;
                    ready_d = mem_valid;
                    state_d = S_DONE;
                end else if (TIMEOUT_EN && timer_q == TIMER_LAST) begin
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    stale_r_d = 1'b1;
                    ready_d   = mem_valid;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_WR: begin
                if (mem_axi_awvalid && mem_axi_awready) aw_done_d = 1'b1;
                if (mem_axi_wvalid && mem_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = S_B_RESP;
                    timer_d = '0;
                end
            end
            S_B_RESP: begin
                if (mem_axi_bvalid && mem_axi_bready) begin
                    error_d = 1'b0;
                    ready_d = mem_valid;
                    state_d = S_DONE;
                end else if (TIMEOUT_EN && timer_q == TIMER_LAST) begin
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    stale_b_d = 1'b1;
                    ready_d   = mem_valid;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Output flops are loaded from the next-state view so they line up
        // with the state they belong to.
        arvalid_d = (state_d == S_AR);
        awvalid_d = (state_d == S_WR) && !aw_done_d;
        wvalid_d  = (state_d == S_WR) && !w_done_d;
        rready_d  = (state_d == S_R_RESP) || stale_r_d;
        bready_d  = (state_d == S_B_RESP) || stale_b_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            stale_r_q       <= 1'b0;
            stale_b_q       <= 1'b0;
            timer_q         <= '0;
            mem_ready       <= 1'b0;
            mem_rdata       <= '0;
            mem_error       <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_rready  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            instr_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            aw_done_q       <= aw_done_d;
            w_done_q        <= w_done_d;
            stale_r_q       <= stale_r_d;
            stale_b_q       <= stale_b_d;
            timer_q         <= timer_d;
            mem_ready       <= ready_d;
            mem_rdata       <= rdata_d;
            mem_error       <= error_d;
            mem_axi_arvalid <= arvalid_d;
            mem_axi_awvalid <= awvalid_d;
            mem_axi_wvalid  <= wvalid_d;
            mem_axi_rready  <= rready_d;
            mem_axi_bready  <= bready_d;
            if (capture) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
        end
    end

    assign mem_axi_araddr = addr_q;
    assign mem_axi_arprot = {instr_q, 2'b00};
    assign mem_axi_awaddr = addr_q;
    assign mem_axi_awprot = 3'b000;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;

endmodule
